// File: rtl/sync_word_inserter_if.sv
// sync_word_inserter_if: bit-serial framer bus.
// Groups the payload input handshake, the framed output handshake and the
// frame status outputs of sync_word_inserter. The master modport is the
// framer itself; the slave modport is the surrounding source/sink.
`default_nettype none

interface sync_word_inserter_if #(
  parameter int FRAME_CNT_W = 16
) ();

  // payload side
  logic                   in_bit;
  logic                   in_valid;
  logic                   in_ready;

  // framed bitstream side
  logic                   out_bit;
  logic                   out_valid;
  logic                   out_ready;

  // status
  logic                   frame_start;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    input  in_bit,
    input  in_valid,
    output in_ready,
    output out_bit,
    output out_valid,
    input  out_ready,
    output frame_start,
    output frame_count
  );

  modport slave (
    output in_bit,
    output in_valid,
    input  in_ready,
    input  out_bit,
    input  out_valid,
    output out_ready,
    input  frame_start,
    input  frame_count
  );

endinterface

`default_nettype wire

// File: rtl/sync_word_inserter.sv
// sync_word_inserter: transmit-side framer.
// Emits frames of SYNC_WORD (MSB first) followed by exactly PAYLOAD_BITS
// payload bits taken from a bit-serial valid/ready source, through a single
// registered output stage with valid/ready backpressure.
// Optional build macro SYNC_INS_SCRAMBLE_EN: XOR the payload (never the sync
// word) with the CCSDS pseudo-noise sequence x^8+x^7+x^5+x^3+1, reseeded to
// 8'hFF at the start of every payload section.
`default_nettype none

module sync_word_inserter #(
  parameter int                  SYNC_LEN     = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 8'h27,
  parameter int                  PAYLOAD_BITS = 72,
  parameter int                  FRAME_CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             sys_rst_n,
  sync_word_inserter_if.master  bus
);

  // Bit index counter covers both the sync word and the payload section.
  localparam int MAX_LEN  = (SYNC_LEN > PAYLOAD_BITS) ? SYNC_LEN : PAYLOAD_BITS;
  localparam int CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SYNC_TBL = 1 << CNT_W;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    DRAIN
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                   out_bit_reg, out_bit_next;
  logic                   out_valid_reg, out_valid_next;
  logic                   frame_start_reg, frame_start_next;
  logic [FRAME_CNT_W-1:0] frame_count_reg, frame_count_next;

  logic                   load_en;
  logic                   in_ready;
  logic                   in_hs;
  logic                   out_hs;
  logic                   scramble_bit;

  // Sync word re-ordered so that table entry k is the k-th transmitted bit.
  // The table is padded to the full counter range so any counter value
  // indexes a defined entry.
  logic [SYNC_TBL-1:0]    sync_tbl;

  for (genvar gi = 0; gi < SYNC_TBL; gi++) begin : g_sync_tbl
    if (gi < SYNC_LEN) begin : g_used
      assign sync_tbl[gi] = SYNC_WORD[SYNC_LEN-1-gi];
    end else begin : g_pad
      assign sync_tbl[gi] = 1'b0;
    end
  end

  // The output register may take a new bit when it is empty or being drained.
  assign load_en = !out_valid_reg || bus.out_ready;
  assign in_hs   = bus.in_valid && in_ready;
  assign out_hs  = out_valid_reg && bus.out_ready;

`ifdef SYNC_INS_SCRAMBLE_EN
  // Fibonacci window of the PN sequence: bit 7 is the current chip, bit 0
  // the newest. Next chip a(n+8) = a(n+7) ^ a(n+5) ^ a(n+3) ^ a(n).
  logic [7:0] lfsr_reg, lfsr_next;

  assign scramble_bit = lfsr_reg[7];

  // Hold the seed outside the payload section; step once per accepted bit.
  always_comb begin
    lfsr_next = lfsr_reg;
    if (state_reg != PAYLOAD) begin
      lfsr_next = 8'hFF;
    end else if (in_hs) begin
      lfsr_next = {lfsr_reg[6:0], lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[4] ^ lfsr_reg[7]};
    end
  end

  // PN generator state register.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      lfsr_reg <= 8'hFF;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end
`else
  assign scramble_bit = 1'b0;
`endif

  // Framing FSM: next state, output-register load values and counters.
  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    out_bit_next     = out_bit_reg;
    out_valid_next   = out_valid_reg;
    frame_start_next = 1'b0;
    frame_count_next = frame_count_reg;
    in_ready         = 1'b0;

    case (state_reg)
      IDLE: begin
        // A pending payload bit only triggers the frame; it is not consumed.
        if (bus.in_valid) begin
          state_next   = SYNC;
          bit_cnt_next = '0;
        end
      end

      SYNC: begin
        // The sync word runs to completion regardless of in_valid.
        if (load_en) begin
          out_bit_next     = sync_tbl[bit_cnt_reg];
          out_valid_next   = 1'b1;
          frame_start_next = (bit_cnt_reg == '0);
          if (bit_cnt_reg == SYNC_LAST) begin
            state_next   = PAYLOAD;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_ONE;
          end
        end
      end

      PAYLOAD: begin
        in_ready = load_en;
        if (load_en) begin
          if (bus.in_valid) begin
            out_bit_next   = bus.in_bit ^ scramble_bit;
            out_valid_next = 1'b1;
            if (bit_cnt_reg == PAY_LAST) begin
              state_next   = DRAIN;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + CNT_ONE;
            end
          end else begin
            // Underrun: leave a gap but keep the payload position.
            out_valid_next = 1'b0;
          end
        end
      end

      DRAIN: begin
        // The last payload bit sits in the output register. When it leaves,
        // either start the next frame in the same cycle or go idle.
        if (out_hs) begin
          frame_count_next = frame_count_reg + FRAME_CNT_W'(1);
          if (bus.in_valid) begin
            out_bit_next     = sync_tbl[0];
            out_valid_next   = 1'b1;
            frame_start_next = 1'b1;
            state_next       = SYNC;
            bit_cnt_next     = CNT_ONE;
          end else begin
            out_valid_next = 1'b0;
            state_next     = IDLE;
            bit_cnt_next   = '0;
          end
        end
      end

      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  // State, counter and output-stage registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      out_bit_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      out_bit_reg     <= out_bit_next;
      out_valid_reg   <= out_valid_next;
      frame_start_reg <= frame_start_next;
      frame_count_reg <= frame_count_next;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_bit     = out_bit_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.frame_count = frame_count_reg;

endmodule

`default_nettype wire

// File: tb/tb_sync_word_inserter.sv
// tb_sync_word_inserter: self-checking bench for sync_word_inserter.
// A frame-level model (sync word then the accepted payload bits in order,
// optionally XORed with the PN sequence) is compared against the DUT on
// every cycle, alongside a few literal expectations.
`timescale 1ns/1ps

module tb_sync_word_inserter;

  localparam int          SYNC_LEN     = 8;
  localparam logic [7:0]  SYNC_WORD    = 8'h27;
  localparam int          PAYLOAD_BITS = 72;
  localparam int          FRAME_LEN    = SYNC_LEN + PAYLOAD_BITS;
  localparam int          FRAME_CNT_W  = 16;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  sync_word_inserter_if #(.FRAME_CNT_W(FRAME_CNT_W)) bus ();

  sync_word_inserter #(
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_WORD    (SYNC_WORD),
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .FRAME_CNT_W  (FRAME_CNT_W)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [7:0] sync_pat;
  int   pos;          // frame position of the next output handshake
  logic in_q[$];      // accepted payload bits not yet seen on the output
  logic cap[$];       // every output bit handshaked since the last reset
  int   in_acc;       // payload bits accepted since the last reset
  int   model_fc;     // frames completed since the last reset
  logic prev_stall;
  logic prev_bit;
  int   stall_seen;

`ifdef SYNC_INS_SCRAMBLE_EN
  logic prn[PAYLOAD_BITS];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic scr(input int p);
`ifdef SYNC_INS_SCRAMBLE_EN
    return prn[p];
`else
    return (p < 0) ? 1'b1 : 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    pos        = 0;
    in_q.delete();
    cap.delete();
    in_acc     = 0;
    model_fc   = 0;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
  endfunction

  function automatic logic [31:0] get_bits(input int start, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[30:0], (start + i < cap.size()) ? cap[start+i] : 1'b0};
    end
    return r;
  endfunction

  // Per-cycle compare against the frame-level model, sampled mid-cycle.
  always @(negedge clk) begin
    logic exp_bit;
    logic exp_rdy;
    logic exp_fs;
    if (!sys_rst_n) begin
      model_reset();
    end else if (mon_en) begin
      check("frame_count", 32'(bus.frame_count), 32'(model_fc % 65536));
      exp_rdy = bus.out_valid ? (bus.out_ready && pos >= SYNC_LEN - 1 && pos < FRAME_LEN - 1)
                              : (pos >= SYNC_LEN);
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      exp_fs = bus.out_valid && (pos == 0) && !prev_stall;
      check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_bit", 32'(bus.out_bit), 32'(prev_bit));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (pos < SYNC_LEN) begin
          exp_bit = sync_pat[SYNC_LEN-1-pos];
          check("sync_bit", 32'(bus.out_bit), 32'(exp_bit));
        end else if (in_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL payload_source: got output at pos %0d, expected no payload bit available", pos);
        end else begin
          exp_bit = in_q.pop_front() ^ scr(pos - SYNC_LEN);
          check("payload_bit", 32'(bus.out_bit), 32'(exp_bit));
        end
        cap.push_back(bus.out_bit);
        if (pos == FRAME_LEN - 1) begin
          pos = 0;
          model_fc++;
          $display("frame %0d complete at t=%0t", model_fc, $time);
        end else begin
          pos++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        in_q.push_back(bus.in_bit);
        in_acc++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bit   = bus.out_bit;
      if (prev_stall) stall_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    sys_rst_n     = 1'b0;
    repeat (n) tick();
    sys_rst_n     = 1'b1;
  endtask

  // Watchdog: never let the run hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fs_cnt;
    int fs_pos;
    int gaps;
    int hold;
    logic seen80;
    logic dropped;
    logic [31:0] exp_pay;

    sync_pat = SYNC_WORD;
    stall_seen = 0;
    model_reset();
`ifdef SYNC_INS_SCRAMBLE_EN
    for (int n = 0; n < PAYLOAD_BITS; n++) begin
      prn[n] = (n < 8) ? 1'b1 : (prn[n-1] ^ prn[n-3] ^ prn[n-5] ^ prn[n-8]);
    end
    exp_pay = 32'hFF480EC0;
`else
    exp_pay = 32'h00000000;
`endif

    // ---- reset state
    do_reset(3);
    mon_en = 1'b1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bit", 32'(bus.out_bit), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_frame_start", 32'(bus.frame_start), 32'd0);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    $display("test reset done");

    // ---- all-zero payload, continuous flow, three frames
    bus.in_valid = 1'b1; bus.in_bit = 1'b0; bus.out_ready = 1'b1;
    fs_cnt = 0; fs_pos = -1; gaps = 0; seen80 = 1'b0;
    for (int c = 0; c < 1000 && cap.size() < 3 * FRAME_LEN; c++) begin
      tick();
      if (bus.frame_start && cap.size() < FRAME_LEN) begin
        fs_cnt++;
        if (fs_pos < 0) fs_pos = cap.size();
      end
      if (cap.size() > 0 && cap.size() < 3 * FRAME_LEN && !bus.out_valid) gaps++;
      if (cap.size() == FRAME_LEN && !seen80) begin
        check("fc_after_frame1", 32'(bus.frame_count), 32'd1);
        seen80 = 1'b1;
      end
    end
    check("zero_timeout", 32'(cap.size()), 32'(3 * FRAME_LEN));
    check("zero_sync0", get_bits(0, 8), 32'h27);
    check("zero_pay0", get_bits(8, 32), exp_pay);
    check("zero_sync1", get_bits(80, 8), 32'h27);
    check("zero_sync2", get_bits(160, 8), 32'h27);
    check("zero_fs_count", 32'(fs_cnt), 32'd1);
    check("zero_fs_pos", 32'(fs_pos), 32'd0);
    check("zero_gaps", 32'(gaps), 32'd0);
    check("fc_after_frame3", 32'(bus.frame_count), 32'd3);
    $display("test continuous done");

    // ---- all-ones payload
    do_reset(2);
    bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && cap.size() < 40; c++) tick();
    check("ones_sync0", get_bits(0, 8), 32'h27);
    check("ones_pay0", get_bits(8, 32), ~exp_pay);
    $display("test ones done");

    // ---- out_ready toggling 1010...
    do_reset(2);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    stall_seen = 0;
    for (int c = 0; c < 1000 && cap.size() < 100; c++) begin
      bus.in_bit = 1'($urandom);
      tick();
      bus.out_ready = ~bus.out_ready;
    end
    check("stall_timeout", 32'(cap.size() >= 100), 32'd1);
    check("stall_sync0", get_bits(0, 8), 32'h27);
    check("stall_seen", 32'(stall_seen > 0), 32'd1);
    $display("test stall done");

    // ---- 5-cycle underrun at payload bit 10
    do_reset(2);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    gaps = 0; dropped = 1'b0; hold = 0;
    for (int c = 0; c < 400 && cap.size() < FRAME_LEN; c++) begin
      tick();
      if (cap.size() > 0 && cap.size() < FRAME_LEN && !bus.out_valid) gaps++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) bus.in_valid = 1'b1;
      end else if (!dropped && in_acc == 10) begin
        bus.in_valid = 1'b0;
        dropped = 1'b1;
        hold = 5;
      end
      bus.in_bit = 1'($urandom);
    end
    check("underrun_timeout", 32'(cap.size()), 32'(FRAME_LEN));
    check("underrun_gaps", 32'(gaps), 32'd5);
    check("underrun_fc", 32'(bus.frame_count), 32'd1);
    $display("test underrun done");

    // ---- reset pulse at payload bit 30
    do_reset(2);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 400 && in_acc < 31; c++) begin
      bus.in_bit = 1'($urandom);
      tick();
    end
    check("midrst_reach", 32'(in_acc >= 31), 32'd1);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_fc", 32'(bus.frame_count), 32'd0);
    check("midrst_fs", 32'(bus.frame_start), 32'd0);
    for (int c = 0; c < 100 && cap.size() < 8; c++) begin
      bus.in_bit = 1'($urandom);
      tick();
    end
    check("midrst_sync", get_bits(0, 8), 32'h27);
    $display("test midframe reset done");

    // ---- randomized traffic
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_bit    = 1'($urandom);
      bus.out_ready = ($urandom % 10) < 7;
      tick();
    end
    check("random_progress", 32'(bus.frame_count >= 5), 32'd1);
    $display("test random done, %0d frames", model_fc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_word_inserter.md
Name: sync_word_inserter

Overview:
- Transmit-side framer: serialises payload bits into frames of one SYNC_WORD followed by exactly PAYLOAD_BITS payload bits.
- Produces the bitstream that the correlator/frame-sync path locks onto.
- Used as the stimulus/loopback source for decoder bring-up and as the framing stage of any on-chip test transmitter.
- Bit-serial valid/ready on both sides; one registered output stage.

Parameters:
- SYNC_LEN, 8, width of the sync word in bits (≥2).
- SYNC_WORD, 8'h27, sync pattern; transmitted MSB first.
- PAYLOAD_BITS, 72, payload bits per frame (≥1); frame length is SYNC_LEN+PAYLOAD_BITS = 80 by default.
- FRAME_CNT_W, 16, width of the frame counter output.

Ports:
- clk  input  1  system clock
- sys_rst_n  input  1  synchronous, active-low reset
- in_bit  input  1  payload bit
- in_valid  input  1  in_bit valid
- in_ready  output  1  payload bit accepted when in_valid&&in_ready
- out_bit  output  1  serial frame bit
- out_valid  output  1  out_bit valid
- out_ready  input  1  downstream accepts out_bit when out_valid&&out_ready
- frame_start  output  1  one-cycle pulse on the cycle the first sync bit is first presented
- frame_count  output  FRAME_CNT_W  number of frames whose last payload bit has been accepted downstream; wraps modulo 2^FRAME_CNT_W

Behaviour:
- Reset (sys_rst_n low at a clk edge, synchronous only; asynchronous sampling of reset is forbidden):
  - state=IDLE; out_bit=0, out_valid=0, in_ready=0, frame_start=0, frame_count=0; internal bit counters=0.
  - Reset asserted mid-frame aborts the frame immediately; the partial frame is not counted.
- Output register: load_en = !out_valid || out_ready. The register loads a new bit only when load_en is high and a bit is available; otherwise out_bit/out_valid hold. out_bit must be stable while out_valid&&!out_ready.
- FSM:
  - IDLE: in_ready=0. Go to SYNC when in_valid=1. The payload bit is not consumed; sync transmission does not wait for payload.
  - SYNC:
    - in_ready=0.
    - Each load_en cycle loads SYNC_WORD[SYNC_LEN-1-k] for k=0..SYNC_LEN-1, with out_valid=1.
    - frame_start pulses on the cycle k=0 is loaded.
    - After k=SYNC_LEN-1 is loaded, go to PAYLOAD.
  - PAYLOAD:
    - in_ready = load_en (combinational from out_valid/out_ready).
    - On an input handshake, out_bit<=in_bit (scrambled if enabled) and out_valid<=1. Input-to-output latency is 1 cycle.
    - If load_en && !in_valid: out_valid<=0. This is an underrun gap; framing position is kept.
    - After the PAYLOAD_BITS-th input handshake, go to DRAIN.
  - DRAIN:
    - in_ready=0.
    - When the last payload bit handshakes on the output, frame_count increments.
    - Then go to SYNC if in_valid=1, else IDLE. Back-to-back frames therefore have no gap bit.
    - If out_ready is already high when the last bit is loaded, DRAIN lasts 1 cycle, and the next sync bit is loaded in that same cycle.
- Counters: bit index width $clog2(max(SYNC_LEN,PAYLOAD_BITS)); reset to 0 on entry to each state.
- Simultaneous events:
  - out_ready low with in_valid high: nothing is consumed.
  - in_valid deasserting during SYNC has no effect; the sync word always completes.

Optional Feature:
- Macro SYNC_INS_SCRAMBLE_EN.
- When defined:
  - Payload bits are XORed with the CCSDS pseudo-noise sequence, polynomial x^8+x^7+x^5+x^3+1, 8-bit LFSR.
  - The LFSR is seeded to 8'hFF on entry to PAYLOAD and advances once per input handshake.
  - The sequence starts FF 48 0E C0 9A (MSB first).
  - Sync bits are never scrambled.
- When undefined: payload passes through unmodified and no LFSR logic exists.

Test Plan:
- Reset, then in_valid=1 with in_bit=0 constant and out_ready=1 → first 8 output bits 0,0,1,0,0,1,1,1 (8'h27); frame_start high only with the first bit; next 72 bits all 0; frame_count=1 after bit 80.
- Continuous in_valid, out_ready=1, 3 frames → output bits 80, 160 and 240 end frames with no gap; sync at positions 0, 80, 160; frame_count=3.
- out_ready toggled 1010… during sync and payload → out_bit held while stalled; the captured stream is identical to the stall-free stream; no payload bit is lost or duplicated.
- in_valid dropped for 5 cycles at payload bit 10 → out_valid=0 for 5 cycles, then payload resumes at bit 10; the frame still contains exactly 72 payload bits.
- sys_rst_n low for 1 cycle at payload bit 30 → next cycle out_valid=0 and frame_count unchanged; a fresh frame starts with 8'h27.
- With SYNC_INS_SCRAMBLE_EN and all-zero payload → payload bits 0..15 = 1111_1111_0100_1000 (FF 48); with all-ones payload → their complement; sync unchanged.
